// File: rtl/axis_loopback_pkg.sv
// Shared constants and width helpers for the AXI-Stream loopback FIFO.
package axis_loopback_pkg;

    // Width of the completed-packet counter on the master side.
    localparam int PKT_CNT_W = 16;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Pointer width: one extra MSB separates the full and empty cases.
    function automatic int ptr_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    // Storage entry width: tdata plus tlast.
    function automatic int entry_w(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// FIFO storage array: registered write port, combinational read port.
module axis_fifo_mem
    import axis_loopback_pkg::*;
#(
    parameter int ENTRY_W = 9,
    parameter int DEPTH   = 16,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               wr_en_i,
    input  logic [ADDR_W-1:0]  wr_addr_i,
    input  logic [ENTRY_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]  rd_addr_i,
    output logic [ENTRY_W-1:0] rd_data_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    // Write port: storage is not reset, pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port is combinational so the head entry falls through to the output.
    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/axis_loopback_fifo.sv
// Elastic AXI-Stream loopback: slave beats are buffered as {tlast, tdata}
// and replayed on the master side, either cut-through or store-and-forward.
//
// Handshake rule on both streams: a beat transfers on a rising edge where
// tvalid and tready are both high; tvalid never depends on tready, and once
// m_axis_tvalid is high it and the presented beat stay stable until taken.
module axis_loopback_fifo
    import axis_loopback_pkg::*;
#(
    parameter int c_WIDTH       = 8,
    parameter int c_DEPTH       = 16,
    parameter int c_PACKET_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [c_WIDTH-1:0]    s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [c_WIDTH-1:0]    m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [clog2(c_DEPTH):0] occupancy,
    output logic [PKT_CNT_W-1:0]  pkt_count
);

    localparam int PTR_W   = ptr_w(c_DEPTH);
    localparam int ADDR_W  = PTR_W - 1;
    localparam int ENTRY_W = entry_w(c_WIDTH);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(c_DEPTH);

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     stored_q, stored_d;
    logic                 cut_q, cut_d;
    logic                 s_ready_q, s_ready_d;
    logic [PKT_CNT_W-1:0] pkt_q, pkt_d;

    logic [PTR_W-1:0]   occ;
    logic [PTR_W-1:0]   occ_d;
    logic               full;
    logic               empty;
    logic               m_valid;
    logic               wr_en;
    logic               rd_en;
    logic               wr_last;
    logic               rd_last;
    logic [ENTRY_W-1:0] rd_data;

    assign occ     = wr_ptr_q - rd_ptr_q;
    assign full    = (occ == DEPTH_P);
    assign empty   = (occ == '0);
    assign wr_en   = s_axis_tvalid && s_ready_q;
    assign rd_en   = m_valid && m_axis_tready;
    assign wr_last = wr_en && s_axis_tlast;
    assign rd_last = rd_en && rd_data[c_WIDTH];

    axis_fifo_mem #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (c_DEPTH)
    ) u_mem (
        .clk_i     (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
        .wr_data_i ({s_axis_tlast, s_axis_tdata}),
        .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
        .rd_data_o (rd_data)
    );

    // Master valid: cut-through shows any stored word; store-and-forward waits
    // for a complete packet, or for a full FIFO (a packet longer than the
    // FIFO), after which the rest of that packet keeps flowing via cut_q.
    always_comb begin
        m_valid = 1'b0;
        if (c_PACKET_MODE == 0) begin
            m_valid = !empty;
        end else begin
            m_valid = !empty && ((stored_q != '0) || full || cut_q);
        end
    end

    // Next-state: pointers, registered ready, packet bookkeeping.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d  = rd_ptr_q + PTR_W'(rd_en);
        occ_d     = wr_ptr_d - rd_ptr_d;
        s_ready_d = (occ_d != DEPTH_P);
        stored_d  = stored_q;
        if (wr_last && !rd_last) begin
            stored_d = stored_q + 1'b1;
        end else if (rd_last && !wr_last) begin
            stored_d = stored_q - 1'b1;
        end
        cut_d = cut_q;
        if (rd_last) begin
            cut_d = 1'b0;
        end else if (full && (stored_q == '0)) begin
            cut_d = 1'b1;
        end
        pkt_d = pkt_q + PKT_CNT_W'(rd_last);
    end

    // State registers with asynchronous clear; partial packets are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            stored_q  <= '0;
            cut_q     <= 1'b0;
            s_ready_q <= 1'b0;
            pkt_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            stored_q  <= stored_d;
            cut_q     <= cut_d;
            s_ready_q <= s_ready_d;
            pkt_q     <= pkt_d;
        end
    end

    assign s_axis_tready = s_ready_q;
    assign m_axis_tvalid = m_valid;
    assign m_axis_tdata  = rd_data[c_WIDTH-1:0];
    assign m_axis_tlast  = rd_data[c_WIDTH];
    assign occupancy     = occ;
    assign pkt_count     = pkt_q;

endmodule

// File: tb/tb_axis_loopback_fifo.sv
// Bench for axis_loopback_fifo: three instances (depth 16 cut-through,
// depth 16 store-and-forward, depth 4 store-and-forward), one active at a time.
module tb_axis_loopback_fifo;

    logic clk;
    logic rst;

    logic [2:0]      s_tvalid;
    logic [2:0]      s_tlast;
    logic [2:0]      m_tready;
    logic [2:0][7:0] s_tdata;

    logic [2:0]       s_tready;
    logic [2:0]       m_tvalid;
    logic [2:0]       m_tlast;
    logic [2:0][7:0]  m_tdata;
    logic [2:0][4:0]  occ;
    logic [2:0][15:0] pkt;
    logic [2:0]       occ_small;

    int total;
    int bad;
    int sel;

    logic [8:0] exp_q[$];

    typedef struct {
        int         dut;
        logic       vld;
        logic [7:0] data;
        logic       last;
        logic       exp_mv;
        logic [4:0] exp_occ;
    } vec_t;

    vec_t vecs [14];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    axis_loopback_fifo #(.c_WIDTH(8), .c_DEPTH(16), .c_PACKET_MODE(0)) dut0 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
        .s_axis_tlast(s_tlast[0]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
        .m_axis_tlast(m_tlast[0]),
        .occupancy(occ[0]), .pkt_count(pkt[0])
    );

    axis_loopback_fifo #(.c_WIDTH(8), .c_DEPTH(16), .c_PACKET_MODE(1)) dut1 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
        .s_axis_tlast(s_tlast[1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
        .m_axis_tlast(m_tlast[1]),
        .occupancy(occ[1]), .pkt_count(pkt[1])
    );

    axis_loopback_fifo #(.c_WIDTH(8), .c_DEPTH(4), .c_PACKET_MODE(1)) dut2 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata[2]), .s_axis_tvalid(s_tvalid[2]), .s_axis_tready(s_tready[2]),
        .s_axis_tlast(s_tlast[2]),
        .m_axis_tdata(m_tdata[2]), .m_axis_tvalid(m_tvalid[2]), .m_axis_tready(m_tready[2]),
        .m_axis_tlast(m_tlast[2]),
        .occupancy(occ_small), .pkt_count(pkt[2])
    );

    assign occ[2] = {2'b00, occ_small};

    // ---------------- scoreboard monitor ----------------
    logic       prev_v;
    logic       prev_hs;
    logic [8:0] prev_word;

    always @(negedge clk) begin
        logic [8:0] got;
        logic [8:0] want;
        got = {m_tlast[sel], m_tdata[sel]};
        if (rst) begin
            prev_v  = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (prev_v && !prev_hs) begin
                total++;
                if (!m_tvalid[sel] || got != prev_word) begin
                    bad++;
                    $display("FAIL hold dut%0d: valid=%0b beat=%0h want valid=1 beat=%0h",
                             sel, m_tvalid[sel], got, prev_word);
                end
            end
            if (m_tvalid[sel] && m_tready[sel]) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL beat dut%0d: got %0h want nothing", sel, got);
                end else begin
                    want = exp_q.pop_front();
                    if (got != want) begin
                        bad++;
                        $display("FAIL beat dut%0d: got %0h want %0h", sel, got, want);
                    end
                end
            end
            if (s_tvalid[sel] && s_tready[sel]) begin
                exp_q.push_back({s_tlast[sel], s_tdata[sel]});
            end
            prev_v    = m_tvalid[sel];
            prev_hs   = m_tvalid[sel] && m_tready[sel];
            prev_word = got;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Holds a beat until accepted; leaves tvalid high for back-to-back use.
    task automatic send_word(input logic [7:0] d, input logic l,
                             output logic [4:0] occ_seen, output logic mv_seen);
        logic ok;
        ok = 1'b0;
        occ_seen = '0;
        mv_seen = 1'b0;
        s_tdata[sel]  = d;
        s_tlast[sel]  = l;
        s_tvalid[sel] = 1'b1;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            if (s_tready[sel]) begin
                ok = 1'b1;
                occ_seen = occ[sel];
                mv_seen = m_tvalid[sel];
            end
            cyc();
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept dut%0d: word %0h not taken within 64 cycles", sel, d);
        end
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        s_tvalid[sel] = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (occ[sel] == 0 && exp_q.size() == 0) done = 1'b1;
            cyc();
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL drain dut%0d: occupancy %0d pending %0d after 200 cycles",
                     sel, occ[sel], exp_q.size());
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [4:0] o;
        logic       mv;
        total = 0;
        bad = 0;
        sel = 0;
        s_tvalid = '0;
        s_tlast = '0;
        s_tdata = '0;
        m_tready = '0;
        rst = 1'b1;

        // Cut-through 5-word packet, then store-and-forward 3-word packet.
        vecs[0]  = '{0, 1'b1, 8'h01, 1'b0, 1'b0, 5'd0};
        vecs[1]  = '{0, 1'b1, 8'h02, 1'b0, 1'b1, 5'd1};
        vecs[2]  = '{0, 1'b1, 8'h03, 1'b0, 1'b1, 5'd1};
        vecs[3]  = '{0, 1'b1, 8'h04, 1'b0, 1'b1, 5'd1};
        vecs[4]  = '{0, 1'b1, 8'h05, 1'b1, 1'b1, 5'd1};
        vecs[5]  = '{0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd1};
        vecs[6]  = '{0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0};
        vecs[7]  = '{1, 1'b1, 8'hA0, 1'b0, 1'b0, 5'd0};
        vecs[8]  = '{1, 1'b1, 8'hA1, 1'b0, 1'b0, 5'd1};
        vecs[9]  = '{1, 1'b1, 8'hA2, 1'b1, 1'b0, 5'd2};
        vecs[10] = '{1, 1'b0, 8'h00, 1'b0, 1'b1, 5'd3};
        vecs[11] = '{1, 1'b0, 8'h00, 1'b0, 1'b1, 5'd2};
        vecs[12] = '{1, 1'b0, 8'h00, 1'b0, 1'b1, 5'd1};
        vecs[13] = '{1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0};

        // Reset state
        cyc();
        cyc();
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_mvalid%0d", d), 32'(m_tvalid[d]), 32'd0);
            check($sformatf("rst_sready%0d", d), 32'(s_tready[d]), 32'd0);
            check($sformatf("rst_occ%0d", d), 32'(occ[d]), 32'd0);
            check($sformatf("rst_pkt%0d", d), 32'(pkt[d]), 32'd0);
        end
        rst = 1'b0;
        cyc();
        check("sready_after_rst", 32'(s_tready[0]), 32'd1);

        // Table: tests 1 and 3
        m_tready = 3'b111;
        for (int i = 0; i < 14; i++) begin
            sel = vecs[i].dut;
            s_tvalid[sel] = vecs[i].vld;
            s_tdata[sel]  = vecs[i].data;
            s_tlast[sel]  = vecs[i].last;
            @(negedge clk);
            check($sformatf("vec%0d_mvalid", i), 32'(m_tvalid[sel]), 32'(vecs[i].exp_mv));
            check($sformatf("vec%0d_sready", i), 32'(s_tready[sel]), 32'd1);
            check($sformatf("vec%0d_occ", i), 32'(occ[sel]), 32'(vecs[i].exp_occ));
            cyc();
        end
        s_tvalid = '0;
        check("t1_pkt", 32'(pkt[0]), 32'd1);
        check("t3_pkt", 32'(pkt[1]), 32'd1);

        // Test 2: fill to full, then stream at occupancy c_DEPTH-1
        sel = 0;
        m_tready[0] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_word(8'(8'h10 + i), (i == 15), o, mv);
        end
        s_tdata[0] = 8'h20;
        s_tlast[0] = 1'b0;
        s_tvalid[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("full_sready", 32'(s_tready[0]), 32'd0);
            check("full_occ", 32'(occ[0]), 32'd16);
            check("full_mvalid", 32'(m_tvalid[0]), 32'd1);
            cyc();
        end
        m_tready[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_word(8'(8'h20 + i), (i == 7), o, mv);
            check($sformatf("stream_occ%0d", i), 32'(o), 32'd15);
        end
        wait_drain();
        check("t2_pkt", 32'(pkt[0]), 32'd3);

        // Test 4: depth-4 store-and-forward, 6-word packet forces release
        sel = 2;
        m_tready[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_word(8'(8'hB0 + i), 1'b0, o, mv);
            check($sformatf("sf_hold_mv%0d", i), 32'(mv), 32'd0);
            check($sformatf("sf_hold_occ%0d", i), 32'(o), 32'(i));
        end
        s_tdata[2] = 8'hB4;
        @(negedge clk);
        check("release_occ", 32'(occ[2]), 32'd4);
        check("release_mvalid", 32'(m_tvalid[2]), 32'd1);
        check("release_sready", 32'(s_tready[2]), 32'd0);
        cyc();
        send_word(8'hB4, 1'b0, o, mv);
        check("cut_mv_b4", 32'(mv), 32'd1);
        send_word(8'hB5, 1'b1, o, mv);
        check("cut_mv_b5", 32'(mv), 32'd1);
        wait_drain();
        check("t4_pkt", 32'(pkt[2]), 32'd1);

        // Test 5: asynchronous reset with seven words stored
        sel = 0;
        m_tready[0] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send_word(8'(8'h30 + i), 1'b0, o, mv);
        end
        s_tvalid[0] = 1'b0;
        check("pre_rst_occ", 32'(occ[0]), 32'd7);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("async_mvalid", 32'(m_tvalid[0]), 32'd0);
        check("async_sready", 32'(s_tready[0]), 32'd0);
        check("async_occ", 32'(occ[0]), 32'd0);
        check("async_pkt", 32'(pkt[0]), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("post_rst_sready_low", 32'(s_tready[0]), 32'd0);
        cyc();
        check("post_rst_sready_high", 32'(s_tready[0]), 32'd1);
        m_tready[0] = 1'b1;
        send_word(8'h40, 1'b0, o, mv);
        send_word(8'h41, 1'b1, o, mv);
        wait_drain();
        check("t5_pkt", 32'(pkt[0]), 32'd1);

        // Test 6: packet counter wrap
        for (int i = 0; i < 65534; i++) begin
            send_word(8'(i), 1'b1, o, mv);
        end
        wait_drain();
        check("pkt_ffff", 32'(pkt[0]), 32'h0000FFFF);
        send_word(8'h5A, 1'b1, o, mv);
        wait_drain();
        check("pkt_wrap", 32'(pkt[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
